zrb_sd_block_reader: RTL and testbench

- Sequences the SPI byte engine to perform one SD single-block read (CMD17) after card initialisation has completed.
- Issues the 6-byte command, then polls for R1, then polls for the 0xFE start token, then streams BLOCK_LEN data bytes to the host, then clocks the 2 CRC bytes and 8 trailing dummy clocks.
- Sits between host logic and the byte-level SPI transceiver and owns chip select during the transaction.

---
 rtl/zrb_sd_block_reader_if.sv | 29 ++
 rtl/zrb_sd_block_reader.sv | 258 +++++++++++++++++++++++++
 tb/tb_zrb_sd_block_reader.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/zrb_sd_block_reader_if.sv
// Signal bundle between zrb_sd_block_reader, its host and the SPI byte engine.
// Handshake: xfer_req is a one-cycle pulse issued only while xfer_busy is low and no transfer is
// outstanding; xfer_tx holds from xfer_req until the matching one-cycle xfer_done, which carries xfer_rx.
interface zrb_sd_block_reader_if;
   logic        rd_start;
   logic [31:0] rd_addr;
   logic        busy;
   logic        data_valid;
   logic [7:0]  data_byte;
   logic        done;
   logic [2:0]  error;
   logic        cs_n;
   logic        xfer_req;
   logic [7:0]  xfer_tx;
   logic        xfer_busy;
   logic        xfer_done;
   logic [7:0]  xfer_rx;
   logic [2:0]  dbg_state;

   modport master (
      input  rd_start, rd_addr, xfer_busy, xfer_done, xfer_rx,
      output busy, data_valid, data_byte, done, error, cs_n, xfer_req, xfer_tx, dbg_state
   );

   modport slave (
      output rd_start, rd_addr, xfer_busy, xfer_done, xfer_rx,
      input  busy, data_valid, data_byte, done, error, cs_n, xfer_req, xfer_tx, dbg_state
   );
endinterface

// File: rtl/zrb_sd_block_reader.sv
// SD CMD17 single-block reader: command, R1 poll, token poll, data stream, CRC bytes, CS-high dummy byte.
// Optional CRC-16-CCITT data check is enabled with the macro ZRB_SD_CRC_CHECK_EN.
module zrb_sd_block_reader #(
   parameter int BLOCK_LEN     = 512,
   parameter int RESP_TIMEOUT  = 8,
   parameter int TOKEN_TIMEOUT = 4096,
   parameter int BYTE_ADDR     = 0
) (
   input logic                   clk,
   input logic                   rst,
   zrb_sd_block_reader_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE, S_CMD, S_RESP, S_TOKEN, S_DATA, S_CRC, S_FINISH, S_DONE
   } state_t;

   localparam logic [12:0] LAST_BYTE   = 13'(BLOCK_LEN - 1);
   localparam logic [12:0] RESP_LIMIT  = 13'(RESP_TIMEOUT);
   localparam logic [12:0] TOKEN_LIMIT = 13'(TOKEN_TIMEOUT);

   state_t      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [12:0] cnt_q, cnt_d;
   logic        pending_q, pending_d;
   logic        xfer_req_q, xfer_req_d;
   logic [7:0]  xfer_tx_q, xfer_tx_d;
   logic        cs_n_q, cs_n_d;
   logic        busy_q, busy_d;
   logic        data_valid_q, data_valid_d;
   logic [7:0]  data_byte_q, data_byte_d;
   logic        done_q, done_d;
   logic [2:0]  error_q, error_d;

   logic        rx_ok;
   logic        issue;
   logic        to_finish;
   logic [12:0] cnt_inc;
   logic [7:0]  cmd_byte;
   logic [7:0]  rx;

`ifdef ZRB_SD_CRC_CHECK_EN
   logic [15:0] crc_q, crc_d;
   logic [7:0]  crc_hi_q, crc_hi_d;

   function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] b);
      logic [15:0] r;
      r = c ^ {b, 8'h00};
      for (int i = 0; i < 8; i++) begin
         r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
      end
      return r;
   endfunction
`endif

   // Only a done that answers our own outstanding request is acted upon.
   assign rx      = bus.xfer_rx;
   assign rx_ok   = bus.xfer_done && pending_q;
   assign issue   = (state_q != S_IDLE) && (state_q != S_DONE) && !pending_q && !bus.xfer_busy;
   assign cnt_inc = cnt_q + 13'd1;

   always_comb begin
      cmd_byte = 8'hFF;
      case (cnt_q[2:0])
         3'd0:    cmd_byte = 8'h51;
         3'd1:    cmd_byte = addr_q[31:24];
         3'd2:    cmd_byte = addr_q[23:16];
         3'd3:    cmd_byte = addr_q[15:8];
         3'd4:    cmd_byte = addr_q[7:0];
         default: cmd_byte = 8'hFF;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      cnt_d        = cnt_q;
      pending_d    = pending_q;
      xfer_req_d   = 1'b0;
      xfer_tx_d    = xfer_tx_q;
      cs_n_d       = cs_n_q;
      busy_d       = busy_q;
      data_valid_d = 1'b0;
      data_byte_d  = data_byte_q;
      done_d       = 1'b0;
      error_d      = error_q;
      to_finish    = 1'b0;
`ifdef ZRB_SD_CRC_CHECK_EN
      crc_d        = crc_q;
      crc_hi_d     = crc_hi_q;
`endif

      if (rx_ok) begin
         pending_d = 1'b0;
      end
      if (issue) begin
         xfer_req_d = 1'b1;
         pending_d  = 1'b1;
         xfer_tx_d  = (state_q == S_CMD) ? cmd_byte : 8'hFF;
      end

      case (state_q)
         S_IDLE: begin
            if (bus.rd_start) begin
               addr_d  = (BYTE_ADDR != 0) ? {bus.rd_addr[22:0], 9'd0} : bus.rd_addr;
               error_d = 3'd0;
               busy_d  = 1'b1;
               cs_n_d  = 1'b0;
               cnt_d   = 13'd0;
               state_d = S_CMD;
`ifdef ZRB_SD_CRC_CHECK_EN
               crc_d   = 16'h0000;
`endif
            end
         end
         S_CMD: begin
            if (rx_ok) begin
               if (cnt_q == 13'd5) begin
                  cnt_d   = 13'd0;
                  state_d = S_RESP;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
         end
         S_RESP: begin
            // A real R1 on the last allowed poll wins over the timeout.
            if (rx_ok) begin
               cnt_d = cnt_inc;
               if (rx == 8'h00) begin
                  cnt_d   = 13'd0;
                  state_d = S_TOKEN;
               end else if (rx != 8'hFF) begin
                  error_d   = 3'd2;
                  to_finish = 1'b1;
               end else if (cnt_inc == RESP_LIMIT) begin
                  error_d   = 3'd1;
                  to_finish = 1'b1;
               end
            end
         end
         S_TOKEN: begin
            if (rx_ok) begin
               cnt_d = cnt_inc;
               if (rx == 8'hFE) begin
                  cnt_d   = 13'd0;
                  state_d = S_DATA;
               end else if (rx[7:4] == 4'h0) begin
                  error_d   = 3'd2;
                  to_finish = 1'b1;
               end else if (cnt_inc == TOKEN_LIMIT) begin
                  error_d   = 3'd3;
                  to_finish = 1'b1;
               end
            end
         end
         S_DATA: begin
            if (rx_ok) begin
               data_valid_d = 1'b1;
               data_byte_d  = rx;
`ifdef ZRB_SD_CRC_CHECK_EN
               crc_d        = crc16_byte(crc_q, rx);
`endif
               if (cnt_q == LAST_BYTE) begin
                  cnt_d   = 13'd0;
                  state_d = S_CRC;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
         end
         S_CRC: begin
            if (rx_ok) begin
               if (cnt_q == 13'd1) begin
`ifdef ZRB_SD_CRC_CHECK_EN
                  if ({crc_hi_q, rx} != crc_q) begin
                     error_d = 3'd4;
                  end
`endif
                  to_finish = 1'b1;
               end else begin
`ifdef ZRB_SD_CRC_CHECK_EN
                  crc_hi_d = rx;
`endif
                  cnt_d = cnt_inc;
               end
            end
         end
         S_FINISH: begin
            if (rx_ok) begin
               done_d  = 1'b1;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Chip select rises before the trailing dummy byte is requested.
      if (to_finish) begin
         cnt_d   = 13'd0;
         cs_n_d  = 1'b1;
         state_d = S_FINISH;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         addr_q       <= 32'd0;
         cnt_q        <= 13'd0;
         pending_q    <= 1'b0;
         xfer_req_q   <= 1'b0;
         xfer_tx_q    <= 8'hFF;
         cs_n_q       <= 1'b1;
         busy_q       <= 1'b0;
         data_valid_q <= 1'b0;
         data_byte_q  <= 8'h00;
         done_q       <= 1'b0;
         error_q      <= 3'd0;
`ifdef ZRB_SD_CRC_CHECK_EN
         crc_q        <= 16'h0000;
         crc_hi_q     <= 8'h00;
`endif
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         cnt_q        <= cnt_d;
         pending_q    <= pending_d;
         xfer_req_q   <= xfer_req_d;
         xfer_tx_q    <= xfer_tx_d;
         cs_n_q       <= cs_n_d;
         busy_q       <= busy_d;
         data_valid_q <= data_valid_d;
         data_byte_q  <= data_byte_d;
         done_q       <= done_d;
         error_q      <= error_d;
`ifdef ZRB_SD_CRC_CHECK_EN
         crc_q        <= crc_d;
         crc_hi_q     <= crc_hi_d;
`endif
      end
   end

   assign bus.busy       = busy_q;
   assign bus.data_valid = data_valid_q;
   assign bus.data_byte  = data_byte_q;
   assign bus.done       = done_q;
   assign bus.error      = error_q;
   assign bus.cs_n       = cs_n_q;
   assign bus.xfer_req   = xfer_req_q;
   assign bus.xfer_tx    = xfer_tx_q;
   assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_zrb_sd_block_reader.sv
// Bench for zrb_sd_block_reader: two instances (512-byte SDHC, 4-byte SDSC with short token timeout)
// share one SPI engine model; scenarios come from a vector table plus a mid-transfer reset sequence.
`timescale 1ns/1ps
module tb_zrb_sd_block_reader;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   zrb_sd_block_reader_if if0();
   zrb_sd_block_reader_if if1();

   zrb_sd_block_reader #(.BLOCK_LEN(512), .RESP_TIMEOUT(8), .TOKEN_TIMEOUT(4096), .BYTE_ADDR(0))
      u_dut0 (.clk(clk), .rst(rst), .bus(if0));
   zrb_sd_block_reader #(.BLOCK_LEN(4), .RESP_TIMEOUT(8), .TOKEN_TIMEOUT(16), .BYTE_ADDR(1))
      u_dut1 (.clk(clk), .rst(rst), .bus(if1));

   logic       sel = 1'b0;
   logic       eng_busy = 1'b0;
   logic       eng_done = 1'b0;
   logic [7:0] eng_rx = 8'hFF;
   logic [7:0] eng_tx = 8'hFF;
   int         eng_cnt = 0;
   int         proto_err = 0;

   assign if0.xfer_busy = eng_busy;
   assign if0.xfer_done = eng_done;
   assign if0.xfer_rx   = eng_rx;
   assign if1.xfer_busy = eng_busy;
   assign if1.xfer_done = eng_done;
   assign if1.xfer_rx   = eng_rx;

   logic       m_busy, m_done, m_dv, m_cs_n, m_req;
   logic [7:0] m_db, m_tx;
   logic [2:0] m_err;
   assign m_busy = sel ? if1.busy       : if0.busy;
   assign m_done = sel ? if1.done       : if0.done;
   assign m_dv   = sel ? if1.data_valid : if0.data_valid;
   assign m_cs_n = sel ? if1.cs_n       : if0.cs_n;
   assign m_req  = sel ? if1.xfer_req   : if0.xfer_req;
   assign m_db   = sel ? if1.data_byte  : if0.data_byte;
   assign m_tx   = sel ? if1.xfer_tx    : if0.xfer_tx;
   assign m_err  = sel ? if1.error      : if0.error;

   logic [7:0] rx_q[$];
   logic [7:0] tx_log[$];
   logic       cs_log[$];
   logic [7:0] got_q[$];
   logic [7:0] exp_q[$];
   int         done_cnt = 0;
   logic [2:0] err_at_done = 3'd0;
   logic       busy_at_done = 1'b0;
   int         checks = 0;
   int         errors = 0;

   typedef struct {
      string       name;
      logic        sel;
      logic [31:0] addr;
      int          r1_ff;
      logic [7:0]  r1;
      int          tok_ff;
      logic [7:0]  tok;
      logic        bad_crc;
      int          poke_at;
      logic [2:0]  exp_err;
      int          exp_data;
      int          exp_xfers;
      logic [47:0] exp_cmd;
   } vec_t;

   vec_t vecs[11];

   // SPI engine: accepts a request, stays busy two cycles, then returns the next queued byte.
   always @(negedge clk) begin
      eng_done = 1'b0;
      if (eng_cnt > 0) begin
         if (m_req) proto_err++;
         if (m_tx !== eng_tx) proto_err++;
         eng_cnt--;
         if (eng_cnt == 0) begin
            eng_busy = 1'b0;
            eng_done = 1'b1;
            if (rx_q.size() > 0) eng_rx = rx_q.pop_front();
            else eng_rx = 8'hFF;
         end
      end else if (m_req) begin
         tx_log.push_back(m_tx);
         cs_log.push_back(m_cs_n);
         eng_tx   = m_tx;
         eng_busy = 1'b1;
         eng_cnt  = 2;
      end
   end

   always @(negedge clk) begin
      if (m_dv) got_q.push_back(m_db);
      if (m_done) begin
         done_cnt++;
         err_at_done  = m_err;
         busy_at_done = m_busy;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive_start(input logic s, input logic v, input logic [31:0] a);
      if (s) begin
         if1.rd_start = v;
         if1.rd_addr  = a;
      end else begin
         if0.rd_start = v;
         if0.rd_addr  = a;
      end
   endtask

   function automatic logic [15:0] crc_ccitt(input logic [15:0] c, input logic [7:0] b);
      logic [15:0] r;
      logic        fb;
      r = c;
      for (int k = 7; k >= 0; k--) begin
         fb = r[15] ^ b[k];
         r  = {r[14:0], 1'b0};
         if (fb) r = r ^ 16'h1021;
      end
      return r;
   endfunction

   task automatic build_stream(input vec_t v);
      int          nblk;
      logic [15:0] crc;
      rx_q.delete();
      repeat (6) rx_q.push_back(8'hA5);
      repeat (v.r1_ff) rx_q.push_back(8'hFF);
      rx_q.push_back(v.r1);
      repeat (v.tok_ff) rx_q.push_back(8'hFF);
      rx_q.push_back(v.tok);
      nblk = v.sel ? 4 : 512;
      crc  = 16'h0000;
      for (int i = 0; i < nblk; i++) begin
         rx_q.push_back(8'(i));
         crc = crc_ccitt(crc, 8'(i));
      end
      if (v.bad_crc) crc = crc ^ 16'h0100;
      rx_q.push_back(crc[15:8]);
      rx_q.push_back(crc[7:0]);
   endtask

   task automatic start_read(input vec_t v);
      build_stream(v);
      tx_log.delete();
      cs_log.delete();
      got_q.delete();
      done_cnt  = 0;
      proto_err = 0;
      sel       = v.sel;
      @(negedge clk); #1;
      drive_start(v.sel, 1'b1, v.addr);
      @(negedge clk); #1;
      drive_start(v.sel, 1'b0, v.addr);
   endtask

   task automatic run_vec(input vec_t v);
      int          cyc;
      logic        poked;
      logic [47:0] cmd;
      logic [2:0]  exp_err;
      int          bad_ff;
      int          bad_cs;
      int          mism;
      start_read(v);
      cyc   = 0;
      poked = 1'b0;
      while (done_cnt == 0 && cyc < 6000) begin
         if (v.poke_at >= 0 && !poked && got_q.size() == v.poke_at) begin
            drive_start(v.sel, 1'b1, 32'hDEAD_BEEF);
            poked = 1'b1;
         end else begin
            drive_start(v.sel, 1'b0, v.addr);
         end
         @(negedge clk); #1;
         cyc++;
      end
      drive_start(v.sel, 1'b0, v.addr);
      if (done_cnt == 0) begin
         checks++;
         errors++;
         $display("FAIL %s done_wait: no done after %0d cycles", v.name, cyc);
      end
      check({v.name, " busy_with_done"}, busy_at_done, 1'b1);
      @(negedge clk); #1;
      check({v.name, " busy_after_done"}, m_busy, 1'b0);
      repeat (20) @(negedge clk);
      #1;
      exp_err = v.exp_err;
`ifdef ZRB_SD_CRC_CHECK_EN
      if (v.bad_crc) exp_err = 3'd4;
`endif
      check({v.name, " error"}, err_at_done, exp_err);
      check({v.name, " held_error"}, m_err, exp_err);
      check({v.name, " done_count"}, done_cnt, 1);
      check({v.name, " xfer_count"}, tx_log.size(), v.exp_xfers);
      cmd = 48'd0;
      for (int i = 0; i < 6 && i < tx_log.size(); i++) cmd = {cmd[39:0], tx_log[i]};
      check({v.name, " cmd_bytes"}, cmd, v.exp_cmd);
      bad_ff = 0;
      for (int i = 6; i < tx_log.size(); i++) if (tx_log[i] !== 8'hFF) bad_ff++;
      check({v.name, " tx_ff_after_cmd"}, bad_ff, 0);
      bad_cs = 0;
      for (int i = 0; i < cs_log.size(); i++)
         if (cs_log[i] !== ((i == cs_log.size() - 1) ? 1'b1 : 1'b0)) bad_cs++;
      check({v.name, " cs_n_per_xfer"}, bad_cs, 0);
      check({v.name, " protocol"}, proto_err, 0);
      check({v.name, " cs_n_idle"}, m_cs_n, 1'b1);
      exp_q.delete();
      for (int i = 0; i < v.exp_data; i++) exp_q.push_back(8'(i));
      check({v.name, " data_count"}, got_q.size(), v.exp_data);
      mism = 0;
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         if (got_q.pop_front() !== exp_q.pop_front()) mism++;
      end
      check({v.name, " data_values"}, mism, 0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int ngot;
      int nlog;
      int cyc;
      vecs[0]  = '{"main",          1'b0, 32'h0000_1234, 1, 8'h00, 3,  8'hFE, 1'b0, -1, 3'd0, 512, 527, 48'h510000_1234FF};
      vecs[1]  = '{"r1_timeout",    1'b0, 32'hA1B2_C3D4, 20, 8'hFF, 0, 8'hFF, 1'b0, -1, 3'd1, 0,   15,  48'h51A1B2_C3D4FF};
      vecs[2]  = '{"r1_error",      1'b0, 32'h0000_0000, 0, 8'h05, 0,  8'hFE, 1'b0, -1, 3'd2, 0,   8,   48'h510000_0000FF};
      vecs[3]  = '{"token_error",   1'b0, 32'h0000_0010, 0, 8'h00, 10, 8'h09, 1'b0, -1, 3'd2, 0,   19,  48'h510000_0010FF};
      vecs[4]  = '{"token_timeout", 1'b1, 32'h0000_0003, 0, 8'h00, 40, 8'hFF, 1'b0, -1, 3'd3, 0,   24,  48'h510000_0600FF};
      vecs[5]  = '{"byte_addr_ok",  1'b1, 32'h0000_0003, 2, 8'h00, 0,  8'hFE, 1'b0, -1, 3'd0, 4,   17,  48'h510000_0600FF};
      vecs[6]  = '{"r1_last_poll",  1'b1, 32'h0000_0001, 7, 8'h00, 0,  8'hFE, 1'b0, -1, 3'd0, 4,   22,  48'h510000_0200FF};
      vecs[7]  = '{"r1_exact_to",   1'b1, 32'h0000_0001, 8, 8'h00, 0,  8'hFE, 1'b0, -1, 3'd1, 0,   15,  48'h510000_0200FF};
      vecs[8]  = '{"tok_last_poll", 1'b1, 32'h0000_0002, 0, 8'h00, 15, 8'hFE, 1'b0, -1, 3'd0, 4,   30,  48'h510000_0400FF};
      vecs[9]  = '{"start_in_data", 1'b1, 32'h0000_0003, 0, 8'h00, 0,  8'hFE, 1'b0, 2,  3'd0, 4,   15,  48'h510000_0600FF};
      vecs[10] = '{"bad_crc",       1'b1, 32'h0000_0003, 0, 8'h00, 0,  8'hFE, 1'b1, -1, 3'd0, 4,   15,  48'h510000_0600FF};

      if0.rd_start = 1'b0;
      if0.rd_addr  = 32'd0;
      if1.rd_start = 1'b0;
      if1.rd_addr  = 32'd0;
      rst = 1'b1;
      repeat (4) @(negedge clk);
      #1;
      check("reset0 ctrl", {if0.cs_n, if0.busy, if0.done, if0.data_valid, if0.xfer_req}, 5'b10000);
      check("reset0 data", {if0.error, if0.data_byte, if0.xfer_tx, if0.dbg_state}, {3'd0, 8'h00, 8'hFF, 3'd0});
      check("reset1 ctrl", {if1.cs_n, if1.busy, if1.done, if1.data_valid, if1.xfer_req}, 5'b10000);
      check("reset1 data", {if1.error, if1.data_byte, if1.xfer_tx, if1.dbg_state}, {3'd0, 8'h00, 8'hFF, 3'd0});
      rst = 1'b0;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 11; i++) run_vec(vecs[i]);

      // Reset in the middle of the data phase with a transfer still in flight.
      start_read(vecs[0]);
      cyc = 0;
      while (!(got_q.size() >= 101 && eng_cnt == 2) && cyc < 3000) begin
         @(negedge clk); #1;
         cyc++;
      end
      if (cyc >= 3000) begin
         checks++;
         errors++;
         $display("FAIL mid_reset wait: data byte 100 not reached, got %0d bytes", got_q.size());
      end
      ngot = got_q.size();
      nlog = tx_log.size();
      rst  = 1'b1;
      @(negedge clk); #1;
      check("mid_reset cs_n", if0.cs_n, 1'b1);
      check("mid_reset busy", if0.busy, 1'b0);
      rst = 1'b0;
      repeat (30) @(negedge clk);
      #1;
      check("mid_reset data_after", got_q.size(), ngot);
      check("mid_reset done_after", done_cnt, 0);
      check("mid_reset xfers_after", tx_log.size(), nlog);
      check("mid_reset idle", {if0.cs_n, if0.busy, if0.dbg_state}, {1'b1, 1'b0, 3'd0});

      run_vec(vecs[0]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
